// File: rtl/bus_arb_rr3_wdt.sv
// Three-requester round-robin bus arbiter with a one-cycle settle gap after each
// release and a saturating per-grant watchdog that forces release of a stuck owner.
module bus_arb_rr3_wdt #(
    parameter int WDT_W  = 10,
    parameter int WDT_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       req2,
    input  logic       finish0,
    input  logic       finish1,
    input  logic       finish2,
    input  logic       err_clr,
    output logic       gnt0,
    output logic       gnt1,
    output logic       gnt2,
    output logic [2:0] sel,
    output logic       busy,
    output logic       timeout_err,
    output logic [1:0] timeout_id
);

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

    localparam logic [WDT_W-1:0] CNT_MAX = {WDT_W{1'b1}};
    // One below the limit: the increment that would land on CNT_MAX is the expiry.
    localparam logic [WDT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;

    state_t           state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [2:0]       sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [1:0]       id_q, id_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_q, last_d;
    logic [WDT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;

    logic [2:0] req_vec;
    logic [2:0] fin_vec;
    logic [1:0] prio0, prio1;
    logic [1:0] win;
    logic [2:0] win_onehot;

    assign req_vec = {req2, req1, req0};
    assign fin_vec = {finish2, finish1, finish0};

    function automatic logic [1:0] rr_next(input logic [1:0] k);
        return (k == 2'd2) ? 2'd0 : k + 2'd1;
    endfunction

    assign prio0 = rr_next(last_q);
    assign prio1 = rr_next(prio0);

    always_comb begin
        win = last_q;
        if (req_vec[prio0]) begin
            win = prio0;
        end else if (req_vec[prio1]) begin
            win = prio1;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_onehot
        assign win_onehot[gi] = (win == 2'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 3'b000;
            sel_q   <= 3'b000;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            id_q    <= 2'd0;
            owner_q <= 2'd0;
            last_q  <= 2'd2;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            id_q    <= id_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        err_d   = err_q;
        id_d    = id_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        armed_d = 1'b1;

        // Clear first so a timeout in the same cycle overrides it.
        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // armed_q keeps the first post-reset edge from granting.
                if (armed_q && (|req_vec)) begin
                    state_d = S_OWN;
                    owner_d = win;
                    gnt_d   = win_onehot;
                    sel_d   = win_onehot;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_OWN: begin
                if (fin_vec[owner_q]) begin
                    state_d = S_GAP;
                    gnt_d   = 3'b000;
                    sel_d   = 3'b000;
                    busy_d  = 1'b0;
                    last_d  = owner_q;
                end else if ((WDT_EN != 0) && (cnt_q == CNT_PRE)) begin
                    state_d = S_GAP;
                    gnt_d   = 3'b000;
                    sel_d   = 3'b000;
                    busy_d  = 1'b0;
                    last_d  = owner_q;
                    err_d   = 1'b1;
                    id_d    = owner_q;
                    cnt_d   = CNT_MAX;
                end else if (WDT_EN != 0) begin
                    cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign gnt0        = gnt_q[0];
    assign gnt1        = gnt_q[1];
    assign gnt2        = gnt_q[2];
    assign sel         = sel_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;
    assign timeout_id  = id_q;

endmodule

// File: tb/tb_bus_arb_rr3_wdt.sv
// Directed bench for bus_arb_rr3_wdt: stimulus queues expected grant transactions,
// a negedge monitor pops and checks them as grants begin and end.
module tb_bus_arb_rr3_wdt;

    logic       clk;
    logic       rst_n;
    logic [2:0] req_r;
    logic [2:0] fin_r;
    logic       err_clr;
    logic       gnt0, gnt1, gnt2;
    logic [2:0] sel;
    logic       busy;
    logic       timeout_err;
    logic [1:0] timeout_id;
    logic [2:0] gnt_v;

    logic       nw_req0, nw_fin0;
    logic [2:0] nw_gnt;
    logic [2:0] nw_sel;
    logic       nw_busy, nw_err;
    logic [1:0] nw_id;

    int errors = 0;
    int checks = 0;

    assign gnt_v = {gnt2, gnt1, gnt0};

    bus_arb_rr3_wdt #(.WDT_W(4), .WDT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req_r[0]), .req1(req_r[1]), .req2(req_r[2]),
        .finish0(fin_r[0]), .finish1(fin_r[1]), .finish2(fin_r[2]),
        .err_clr(err_clr),
        .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
        .sel(sel), .busy(busy),
        .timeout_err(timeout_err), .timeout_id(timeout_id)
    );

    bus_arb_rr3_wdt #(.WDT_EN(0)) dut_nw (
        .clk(clk), .rst_n(rst_n),
        .req0(nw_req0), .req1(1'b0), .req2(1'b0),
        .finish0(nw_fin0), .finish1(1'b0), .finish2(1'b0),
        .err_clr(1'b0),
        .gnt0(nw_gnt[0]), .gnt1(nw_gnt[1]), .gnt2(nw_gnt[2]),
        .sel(nw_sel), .busy(nw_busy),
        .timeout_err(nw_err), .timeout_id(nw_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] gnt;
        int         hold;   // -1: expected to be cut by reset, -2: unexpected grant
        logic       err;
        logic [1:0] id;
        bit         gapchk;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [2:0] g, input int h, input logic e, input logic [1:0] id,
                        input bit gap);
        exp_t x;
        x.gnt = g; x.hold = h; x.err = e; x.id = id; x.gapchk = gap;
        exp_q.push_back(x);
    endtask

    // Monitor: grant start pops an expectation; grant end checks hold length and status.
    initial begin
        exp_t cur;
        bit   in_txn;
        bit   bad;
        int   hold_cnt;
        int   zero_cnt;
        in_txn = 0; bad = 0; hold_cnt = 0; zero_cnt = 0;
        cur.gnt = 3'b000; cur.hold = -2; cur.err = 1'b0; cur.id = 2'd0; cur.gapchk = 0;
        forever begin
            @(negedge clk);
            if (!in_txn) begin
                if (gnt_v != 3'b000) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", 32'(gnt_v), 32'd0);
                        cur.gnt = gnt_v; cur.hold = -2; cur.err = 1'b0; cur.gapchk = 0;
                    end else begin
                        cur = exp_q.pop_front();
                        chk("grant", 32'(gnt_v), 32'(cur.gnt));
                        chk("sel", 32'(sel), 32'(cur.gnt));
                        chk("busy", 32'(busy), 32'd1);
                        // GAP cycle plus the IDLE sampling cycle
                        if (cur.gapchk) chk("gap_cycles", 32'(zero_cnt), 32'd2);
                    end
                    in_txn = 1; bad = 0; hold_cnt = 1;
                end else if (rst_n) begin
                    zero_cnt++;
                end
            end else if (gnt_v == 3'b000) begin
                in_txn = 0;
                $display("txn gnt=%b hold=%0d err=%b id=%0d rst_n=%b", cur.gnt, hold_cnt,
                         timeout_err, timeout_id, rst_n);
                if (!rst_n) begin
                    chk("abandon", 32'(cur.hold == -1), 32'd1);
                    zero_cnt = 0;
                end else if (cur.hold >= 0) begin
                    chk("hold", 32'(hold_cnt), 32'(cur.hold));
                    chk("stable", 32'(bad), 32'd0);
                    chk("rel_sel", 32'(sel), 32'd0);
                    chk("rel_busy", 32'(busy), 32'd0);
                    chk("timeout_err", 32'(timeout_err), 32'(cur.err));
                    if (cur.err) chk("timeout_id", 32'(timeout_id), 32'(cur.id));
                    zero_cnt = 1;
                end else begin
                    if (cur.hold == -1) chk("abandon", 32'd0, 32'd1);
                    zero_cnt = 1;
                end
            end else begin
                if (gnt_v != cur.gnt || sel != cur.gnt || !busy) bad = 1;
                hold_cnt++;
            end
        end
    end

    task automatic wait_gnt(input int k, output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (gnt_v[k]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("wait_gnt_timeout", 32'(k), 32'hFFFF);
    endtask

    // Owner k keeps its grant for 'hold' observed cycles, then pulses finish.
    task automatic serve(input int k, input int hold, input bit drop_all);
        bit ok;
        wait_gnt(k, ok);
        if (ok) begin
            repeat (hold - 1) @(negedge clk);
            fin_r[k] = 1'b1;
            @(negedge clk);
            fin_r[k] = 1'b0;
            if (drop_all) req_r = 3'b000;
        end
    endtask

    initial begin
        bit ok;
        int viol;
        rst_n = 1'b0; req_r = 3'b000; fin_r = 3'b000; err_clr = 1'b0;
        nw_req0 = 1'b0; nw_fin0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt_v), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_id", 32'(timeout_id), 32'd0);

        // All requesting from reset: order 0,1,2,0
        req_r = 3'b111;
        push(3'b001, 3, 1'b0, 2'd0, 0);
        push(3'b010, 3, 1'b0, 2'd0, 1);
        push(3'b100, 3, 1'b0, 2'd0, 1);
        push(3'b001, 3, 1'b0, 2'd0, 1);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("no_grant_first_edge", 32'(gnt_v), 32'd0);
        serve(0, 3, 0);
        serve(1, 3, 0);
        serve(2, 3, 0);
        serve(0, 3, 1);
        repeat (3) @(negedge clk);

        // Stray finishes while idle do nothing
        fin_r = 3'b111;
        @(negedge clk);
        fin_r = 3'b000;
        repeat (2) @(negedge clk);
        chk("idle_finish_ignored", 32'({gnt_v, busy}), 32'd0);

        // Non-owner finishes and request changes ignored during gnt1
        req_r = 3'b010;
        push(3'b010, 6, 1'b0, 2'd0, 0);
        wait_gnt(1, ok);
        fin_r[0] = 1'b1;
        @(negedge clk);
        fin_r[0] = 1'b0; req_r[0] = 1'b1;
        @(negedge clk);
        fin_r[2] = 1'b1;
        @(negedge clk);
        fin_r[2] = 1'b0; req_r[0] = 1'b0;
        repeat (2) @(negedge clk);
        fin_r[1] = 1'b1;
        @(negedge clk);
        fin_r[1] = 1'b0; req_r = 3'b000;
        repeat (3) @(negedge clk);

        // Watchdog expiry on requester 2 after 15 owned cycles
        req_r = 3'b100;
        push(3'b100, 15, 1'b1, 2'd2, 0);
        wait_gnt(2, ok);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!gnt_v[2]) begin
                ok = 1;
                break;
            end
        end
        req_r = 3'b000;
        chk("wdt_release_seen", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        chk("err_sticky", 32'(timeout_err), 32'd1);

        // Second expiry while set: id overwritten, set beats a coincident clear
        req_r = 3'b001;
        push(3'b001, 15, 1'b1, 2'd0, 0);
        wait_gnt(0, ok);
        repeat (14) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0; req_r = 3'b000;
        repeat (2) @(negedge clk);
        chk("err_set_wins", 32'(timeout_err), 32'd1);
        chk("err_id_overwrite", 32'(timeout_id), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", 32'(timeout_err), 32'd0);
        repeat (2) @(negedge clk);

        // Finish on the 15th owned cycle beats the watchdog
        req_r = 3'b010;
        push(3'b010, 15, 1'b0, 2'd0, 0);
        serve(1, 15, 1);
        repeat (3) @(negedge clk);

        // Asynchronous reset during ownership
        req_r = 3'b010;
        push(3'b010, -1, 1'b0, 2'd0, 0);
        wait_gnt(1, ok);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt_v), 32'd0);
        chk("async_sel", 32'(sel), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        req_r = 3'b111;
        push(3'b001, 3, 1'b0, 2'd0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("no_grant_after_rst", 32'(gnt_v), 32'd0);
        serve(0, 3, 1);
        repeat (4) @(negedge clk);

        // Watchdog disabled: 2000 owned cycles without release
        nw_req0 = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (nw_gnt[0]) begin
                ok = 1;
                break;
            end
        end
        chk("nw_grant", 32'(ok), 32'd1);
        viol = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (nw_gnt != 3'b001 || nw_sel != 3'b001 || !nw_busy || nw_err) viol++;
        end
        chk("nw_hold_2000", 32'(viol), 32'd0);
        nw_fin0 = 1'b1;
        @(negedge clk);
        nw_fin0 = 1'b0; nw_req0 = 1'b0;
        chk("nw_release", 32'({nw_gnt, nw_busy}), 32'd0);
        chk("nw_err", 32'({nw_err, nw_id}), 32'd0);
        $display("txn nw gnt0 held %0d cycles, err=%b", 2000, nw_err);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
